// File: rtl/host_loader.sv
// host_loader: byte-stream host loader that turns WRITE packets into Wishbone
// single write cycles and controls the CPU reset line.
// Packet format: 0xA5, ADDR_BYTES address bytes (LSB first), length byte L,
// then (L+1) words of DATA_BYTES bytes each (LSB first). 0x5A releases the CPU.
// Optional feature: define HOST_LOADER_TIMEOUT_EN to abort a Wishbone cycle
// that sees no ack/err within TIMEOUT clocks.
module host_loader #(
    parameter int ADDR_BYTES = 4,
    parameter int DATA_BYTES = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic        cpu_rst_o,
    output logic        busy_o,
    output logic        err_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [2:0]  wb_cti_o,
    output logic [1:0]  wb_bte_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        LEN  = 3'd2,
        DATA = 3'd3,
        WB   = 3'd4
    } state_t;

    localparam logic [7:0]  CmdWrite = 8'hA5;
    localparam logic [7:0]  CmdEnd   = 8'h5A;
    localparam logic [1:0]  AddrLast = 2'(ADDR_BYTES - 1);
    localparam logic [1:0]  DataLast = 2'(DATA_BYTES - 1);
    localparam logic [31:0] AddrStep = 32'(DATA_BYTES);
    localparam logic [3:0]  SelMask  = 4'((1 << DATA_BYTES) - 1);

    // Reject illegal parameter values at elaboration time.
    if (ADDR_BYTES < 1 || ADDR_BYTES > 4) begin : gBadAddrBytes
        $error("host_loader: ADDR_BYTES must be 1..4");
    end
    if (DATA_BYTES < 1 || DATA_BYTES > 4) begin : gBadDataBytes
        $error("host_loader: DATA_BYTES must be 1..4");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : gBadTimeout
        $error("host_loader: TIMEOUT must be 1..65535");
    end

    state_t      r_state;
    state_t      w_nextState;
    logic        r_started;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [8:0]  r_count;
    logic [1:0]  r_byteIdx;
    logic        r_cpuRst;
    logic        r_err;
    logic        w_byteFire;
    logic        w_timeout;

    assign byte_ready_o = r_started && (r_state != WB);
    assign w_byteFire   = byte_valid_i && byte_ready_o;

    assign busy_o    = (r_state != IDLE);
    assign cpu_rst_o = r_cpuRst;
    assign err_o     = r_err;
    assign wb_cyc_o  = (r_state == WB);
    assign wb_stb_o  = (r_state == WB);
    assign wb_we_o   = (r_state == WB);
    assign wb_adr_o  = r_addr;
    assign wb_dat_o  = r_data;
    assign wb_sel_o  = r_started ? SelMask : 4'h0;
    assign wb_cti_o  = 3'b000;
    assign wb_bte_o  = 2'b00;

`ifdef HOST_LOADER_TIMEOUT_EN
    logic [15:0] r_timer;

    assign w_timeout = (r_state == WB) && !wb_ack_i && !wb_err_i &&
                       (r_timer == 16'(TIMEOUT - 1));

    // Count cycles spent waiting in WB; restart whenever the bus cycle ends.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_timer <= 16'd0;
        end else if (r_state == WB && !wb_ack_i && !wb_err_i && !w_timeout) begin
            r_timer <= r_timer + 16'd1;
        end else begin
            r_timer <= 16'd0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State register; reset lands in IDLE so cyc/stb drop asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode; a bus error outranks a simultaneous ack.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_byteFire && byte_i == CmdWrite) begin
                    w_nextState = ADDR;
                end
            end
            ADDR: begin
                if (w_byteFire && r_byteIdx == AddrLast) begin
                    w_nextState = LEN;
                end
            end
            LEN: begin
                if (w_byteFire) begin
                    w_nextState = DATA;
                end
            end
            DATA: begin
                if (w_byteFire && r_byteIdx == DataLast) begin
                    w_nextState = WB;
                end
            end
            WB: begin
                if (wb_err_i) begin
                    w_nextState = IDLE;
                end else if (wb_ack_i) begin
                    w_nextState = (r_count == 9'd1) ? IDLE : DATA;
                end else if (w_timeout) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Packet datapath: gather address/data bytes, track words left, flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_started <= 1'b0;
            r_addr    <= 32'd0;
            r_data    <= 32'd0;
            r_count   <= 9'd0;
            r_byteIdx <= 2'd0;
            r_cpuRst  <= 1'b1;
            r_err     <= 1'b0;
        end else begin
            r_started <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_byteFire) begin
                        if (byte_i == CmdWrite) begin
                            r_cpuRst  <= 1'b1;
                            r_addr    <= 32'd0;
                            r_byteIdx <= 2'd0;
                        end else if (byte_i == CmdEnd) begin
                            r_cpuRst <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ADDR: begin
                    if (w_byteFire) begin
                        r_addr[{r_byteIdx, 3'b000} +: 8] <= byte_i;
                        r_byteIdx <= (r_byteIdx == AddrLast) ? 2'd0 : r_byteIdx + 2'd1;
                    end
                end
                LEN: begin
                    if (w_byteFire) begin
                        r_count   <= {1'b0, byte_i} + 9'd1;
                        r_data    <= 32'd0;
                        r_byteIdx <= 2'd0;
                    end
                end
                DATA: begin
                    if (w_byteFire) begin
                        r_data[{r_byteIdx, 3'b000} +: 8] <= byte_i;
                        r_byteIdx <= (r_byteIdx == DataLast) ? 2'd0 : r_byteIdx + 2'd1;
                    end
                end
                WB: begin
                    if (wb_err_i) begin
                        r_err <= 1'b1;
                    end else if (wb_ack_i) begin
                        r_addr  <= r_addr + AddrStep;
                        r_count <= r_count - 9'd1;
                        r_data  <= 32'd0;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                    r_byteIdx <= 2'd0;
                end
            endcase
        end
    end

endmodule
